recall_sched: RTL and testbench
===============================

# recall_sched

Recall-phase sequencer for one neuron core. On each time-step start pulse it walks every neuron and, per neuron, every axon. It drives the status-memory read/write enables and addresses, plus the datapath strobes: accumulator clear/enable, recall-adder B select, threshold compare, membrane buffer and write-back select. It sits between the core's time-step controller and the neuron datapath and status memory; learning sequencing is out of scope.

## Interface
- NUM_NURNS, 256, neurons per core
- NUM_AXONS, 256, axons per neuron
- NURN_CNT_BIT_WIDTH, 8, neuron index width (2^W ≥ NUM_NURNS)
- AXON_CNT_BIT_WIDTH, 8, axon index width (2^W ≥ NUM_AXONS)

Ports:
- clk_i  in  1  clock. One clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  time-step start pulse. Accepted only when busy_o=0.
- busy_o  out  1  high from the cycle after start is accepted through the done_o cycle, inclusive.
- done_o  out  1  single-cycle pulse when the time step is complete.
- nurnAddr_o  out  NURN_CNT_BIT_WIDTH  read address for status port A and weight port E (issue stage).
- axonAddr_o  out  AXON_CNT_BIT_WIDTH  weight port E address and spike-buffer index (issue stage).
- rdEn_A_o  out  1  status port A read enable.
- rdSel_A_o  out  2  port A field: 00 bias, 01 membrane potential, 10 threshold.
- rdEn_E_o  out  1  weight read enable.
- wrEn_B_o  out  1  status port B write enable (execute stage).
- wrAddr_B_o  out  NURN_CNT_BIT_WIDTH  port B neuron address (execute stage).
- rstAcc_o, accEn_o, cmp_th_o, buffMembPot_o  out  1 each  datapath strobes (execute stage).
- sel_rclAdd_B_o  out  2  00 weight, 01 bias, 10 membrane potential.
- sel_wrBackStat_B_o  out  2  01 membrane potential, 10 threshold.

## Operation
- Two-stage pipeline.
  - Issue stage: the FSM drives read enables/addresses, registered at the clock edge.
  - Execute stage: datapath strobes, wrEn_B_o, wrAddr_B_o and the selects are the issue decode delayed by exactly one cycle. This matches the 1-cycle status-memory read latency.
- Issue FSM states: IDLE, CLR, BIAS, WT, MEMB, TH, WB_M, WB_T.
- IDLE:
  - start_i=1 → CLR, nurnCnt=0.
  - Otherwise stay in IDLE.
- Per-state issue and execute:
  - CLR: no read. Execute: rstAcc.
  - BIAS: rdEn_A, sel 00. Execute: accEn, sel_rclAdd_B=01.
  - WT: repeats NUM_AXONS cycles with axonCnt 0..NUM_AXONS-1. rdEn_E, axonAddr=axonCnt. Execute: accEn, sel_rclAdd_B=00. Leaves when axonCnt=NUM_AXONS-1, and axonCnt clears to 0.
  - MEMB: rdEn_A, sel 01. Execute: accEn, sel_rclAdd_B=10.
  - TH: rdEn_A, sel 10. Execute: cmp_th and buffMembPot together; AccReg already holds weights+bias+membrane.
  - WB_M: no read. Execute: wrEn_B, sel_wrBackStat_B=01.
  - WB_T: no read. Execute: wrEn_B, sel_wrBackStat_B=10.
- After WB_T:
  - If nurnCnt<NUM_NURNS-1: nurnCnt+1 → CLR.
  - Else → IDLE, and raise done_o after the last execute cycle.
- Per-neuron cost is NUM_AXONS+6 issue cycles. Neurons run back-to-back; the next neuron's CLR issue overlaps the previous WB_T execute.
- wrAddr_B_o is the delayed nurnCnt, so write-backs target the correct neuron across that overlap.
- Counters never wrap beyond the terminal values above.
- Strobes are mutually exclusive except cmp_th/buffMembPot.

## Timing
- Reset (rst_i=1 at an edge): state IDLE, counters 0, and every output 0 (including done_o, busy_o, selects, addresses).
- Reset mid-step aborts immediately: no done_o, no further strobes or writes.
- start_i accepted at edge T (IDLE) → first issue (CLR, neuron 0) at T+1.
- Last execute at T+NUM_NURNS·(NUM_AXONS+6)+1; done_o at the following cycle; busy_o high T+1..done cycle.
- start_i while busy_o=1, including the done_o cycle, is ignored. A start at the cycle after done_o is accepted.
- Idle outputs: read/write enables and strobes are 0; addresses hold their last value.

## Test plan
- NUM_NURNS=2, NUM_AXONS=4, start at cycle 0:
  - issue cycles 1–20;
  - rstAcc at 2 and 12;
  - cmp_th+buffMembPot at 9 and 19;
  - wrEn_B at 10, 11, 20, 21;
  - done_o only at 22;
  - busy_o high 1–22.
- Same config, check that sel_rclAdd_B_o follows 01,00,00,00,00,10 on the accEn cycles 3–8. axonAddr_o must be 0,1,2,3 at cycles 3–6 with rdEn_E_o high exactly there.
- wrAddr_B_o at cycles 10/11 must be 0 and at 20/21 must be 1, while nurnAddr_o=1 at cycle 11.
- start_i pulsed at cycles 5 and 22: both ignored. A pulse at 23 restarts with CLR issued at 24.
- rst_i asserted at cycle 7: at cycle 8 all outputs are 0, there is no done_o, and a start at cycle 9 begins cleanly at cycle 10.
- NUM_NURNS=1, NUM_AXONS=1: 7 issue cycles, done_o at cycle 9, and no out-of-range axon or neuron address is ever driven.

Source files
------------

// File: rtl/recall_sched_if.sv
// Handshake and datapath-control bundle between recall_sched and its
// neighbours. slave: sequencer side. master: controller/datapath side.
interface recall_sched_if #(
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AXON_CNT_BIT_WIDTH = 8
);
    logic                          start_i;
    logic                          busy_o;
    logic                          done_o;
    logic [NURN_CNT_BIT_WIDTH-1:0] nurnAddr_o;
    logic [AXON_CNT_BIT_WIDTH-1:0] axonAddr_o;
    logic                          rdEn_A_o;
    logic [1:0]                    rdSel_A_o;
    logic                          rdEn_E_o;
    logic                          wrEn_B_o;
    logic [NURN_CNT_BIT_WIDTH-1:0] wrAddr_B_o;
    logic                          rstAcc_o;
    logic                          accEn_o;
    logic                          cmp_th_o;
    logic                          buffMembPot_o;
    logic [1:0]                    sel_rclAdd_B_o;
    logic [1:0]                    sel_wrBackStat_B_o;

    modport slave (
        input  start_i,
        output busy_o, done_o,
        output nurnAddr_o, axonAddr_o,
        output rdEn_A_o, rdSel_A_o, rdEn_E_o,
        output wrEn_B_o, wrAddr_B_o,
        output rstAcc_o, accEn_o, cmp_th_o, buffMembPot_o,
        output sel_rclAdd_B_o, sel_wrBackStat_B_o
    );

    modport master (
        output start_i,
        input  busy_o, done_o,
        input  nurnAddr_o, axonAddr_o,
        input  rdEn_A_o, rdSel_A_o, rdEn_E_o,
        input  wrEn_B_o, wrAddr_B_o,
        input  rstAcc_o, accEn_o, cmp_th_o, buffMembPot_o,
        input  sel_rclAdd_B_o, sel_wrBackStat_B_o
    );
endinterface

// File: rtl/recall_sched.sv
// Recall-phase sequencer: walks every neuron and axon per time step.
// Ports: clk_i, rst_i (sync, active-high), sif (recall_sched_if.slave).
module recall_sched #(
    parameter int NUM_NURNS          = 256,
    parameter int NUM_AXONS          = 256,
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AXON_CNT_BIT_WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    recall_sched_if.slave  sif
);
    localparam int NW = NURN_CNT_BIT_WIDTH;
    localparam int AW = AXON_CNT_BIT_WIDTH;

    localparam logic [NW-1:0] NURN_LAST = NW'(NUM_NURNS - 1);
    localparam logic [AW-1:0] AXON_LAST = AW'(NUM_AXONS - 1);

    localparam logic [1:0] RD_BIAS = 2'b00;
    localparam logic [1:0] RD_MEMB = 2'b01;
    localparam logic [1:0] RD_TH   = 2'b10;
    localparam logic [1:0] ADD_WT   = 2'b00;
    localparam logic [1:0] ADD_BIAS = 2'b01;
    localparam logic [1:0] ADD_MEMB = 2'b10;
    localparam logic [1:0] WB_MEMB = 2'b01;
    localparam logic [1:0] WB_TH   = 2'b10;

    typedef enum logic [2:0] {
        IDLE, CLR, BIAS, WT, MEMB, TH, WB_M, WB_T
    } state_t;

    state_t          state;
    logic [NW-1:0]   nurn_cnt;
    logic [AW-1:0]   axon_cnt;
    logic            rd_en_a;
    logic [1:0]      rd_sel_a;
    logic            rd_en_e;
    logic            wr_en_b;
    logic [NW-1:0]   wr_addr_b;
    logic            rst_acc;
    logic            acc_en;
    logic            cmp_th;
    logic            buff_memb;
    logic [1:0]      sel_rcl;
    logic [1:0]      sel_wb;
    logic            last_ex;
    logic            done;
    logic            busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            nurn_cnt  <= '0;
            axon_cnt  <= '0;
            rd_en_a   <= 1'b0;
            rd_sel_a  <= 2'b00;
            rd_en_e   <= 1'b0;
            wr_en_b   <= 1'b0;
            wr_addr_b <= '0;
            rst_acc   <= 1'b0;
            acc_en    <= 1'b0;
            cmp_th    <= 1'b0;
            buff_memb <= 1'b0;
            sel_rcl   <= 2'b00;
            sel_wb    <= 2'b00;
            last_ex   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Execute stage: decode of the state issued this cycle,
            // lined up with the one-cycle status-memory read latency.
            rst_acc   <= (state == CLR);
            acc_en    <= (state == BIAS) || (state == WT) ||
                         (state == MEMB);
            cmp_th    <= (state == TH);
            buff_memb <= (state == TH);
            wr_en_b   <= (state == WB_M) || (state == WB_T);
            sel_rcl   <= (state == BIAS) ? ADD_BIAS :
                         (state == MEMB) ? ADD_MEMB : ADD_WT;
            sel_wb    <= (state == WB_M) ? WB_MEMB :
                         (state == WB_T) ? WB_TH : 2'b00;
            // Delayed neuron index keeps write-backs on the right
            // neuron while the next neuron's CLR is already issuing.
            if (state != IDLE)
                wr_addr_b <= nurn_cnt;
            last_ex <= (state == WB_T) && (nurn_cnt == NURN_LAST);
            done    <= last_ex;
            if (done)
                busy <= 1'b0;

            // Issue stage: outputs registered with the state they belong to.
            rd_en_a <= 1'b0;
            rd_en_e <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sif.start_i && !busy) begin
                        state    <= CLR;
                        nurn_cnt <= '0;
                        axon_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                CLR: begin
                    state    <= BIAS;
                    rd_en_a  <= 1'b1;
                    rd_sel_a <= RD_BIAS;
                end
                BIAS: begin
                    state   <= WT;
                    rd_en_e <= 1'b1;
                end
                WT: begin
                    if (axon_cnt == AXON_LAST) begin
                        state    <= MEMB;
                        axon_cnt <= '0;
                        rd_en_a  <= 1'b1;
                        rd_sel_a <= RD_MEMB;
                    end else begin
                        axon_cnt <= axon_cnt + AW'(1);
                        rd_en_e  <= 1'b1;
                    end
                end
                MEMB: begin
                    state    <= TH;
                    rd_en_a  <= 1'b1;
                    rd_sel_a <= RD_TH;
                end
                TH:   state <= WB_M;
                WB_M: state <= WB_T;
                WB_T: begin
                    if (nurn_cnt != NURN_LAST) begin
                        state    <= CLR;
                        nurn_cnt <= nurn_cnt + NW'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign sif.busy_o             = busy;
    assign sif.done_o             = done;
    assign sif.nurnAddr_o         = nurn_cnt;
    assign sif.axonAddr_o         = axon_cnt;
    assign sif.rdEn_A_o           = rd_en_a;
    assign sif.rdSel_A_o          = rd_sel_a;
    assign sif.rdEn_E_o           = rd_en_e;
    assign sif.wrEn_B_o           = wr_en_b;
    assign sif.wrAddr_B_o         = wr_addr_b;
    assign sif.rstAcc_o           = rst_acc;
    assign sif.accEn_o            = acc_en;
    assign sif.cmp_th_o           = cmp_th;
    assign sif.buffMembPot_o      = buff_memb;
    assign sif.sel_rclAdd_B_o     = sel_rcl;
    assign sif.sel_wrBackStat_B_o = sel_wb;
endmodule

// File: tb/tb_recall_sched.sv
// Directed bench for recall_sched: 2x4 and 1x1 configurations.
module tb_recall_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    recall_sched_if #(.NURN_CNT_BIT_WIDTH(8), .AXON_CNT_BIT_WIDTH(8)) ifa();
    recall_sched_if #(.NURN_CNT_BIT_WIDTH(1), .AXON_CNT_BIT_WIDTH(1)) ifb();

    recall_sched #(
        .NUM_NURNS(2), .NUM_AXONS(4),
        .NURN_CNT_BIT_WIDTH(8), .AXON_CNT_BIT_WIDTH(8)
    ) dut_a (.clk_i(clk), .rst_i(rst_a), .sif(ifa));

    recall_sched #(
        .NUM_NURNS(1), .NUM_AXONS(1),
        .NURN_CNT_BIT_WIDTH(1), .AXON_CNT_BIT_WIDTH(1)
    ) dut_b (.clk_i(clk), .rst_i(rst_b), .sif(ifb));

    logic [38:0] outs_a;
    logic [16:0] outs_b;
    logic [8:0]  strb_a;
    logic [8:0]  strb_b;

    assign outs_a = {ifa.busy_o, ifa.done_o, ifa.nurnAddr_o,
                     ifa.axonAddr_o, ifa.rdEn_A_o, ifa.rdSel_A_o,
                     ifa.rdEn_E_o, ifa.wrEn_B_o, ifa.wrAddr_B_o,
                     ifa.rstAcc_o, ifa.accEn_o, ifa.cmp_th_o,
                     ifa.buffMembPot_o, ifa.sel_rclAdd_B_o,
                     ifa.sel_wrBackStat_B_o};
    assign outs_b = {ifb.busy_o, ifb.done_o, ifb.nurnAddr_o,
                     ifb.axonAddr_o, ifb.rdEn_A_o, ifb.rdSel_A_o,
                     ifb.rdEn_E_o, ifb.wrEn_B_o, ifb.wrAddr_B_o,
                     ifb.rstAcc_o, ifb.accEn_o, ifb.cmp_th_o,
                     ifb.buffMembPot_o, ifb.sel_rclAdd_B_o,
                     ifb.sel_wrBackStat_B_o};
    // {busy, done, rstAcc, accEn, cmp_th, buffMembPot, wrEn_B, rdEn_E, rdEn_A}
    assign strb_a = {ifa.busy_o, ifa.done_o, ifa.rstAcc_o, ifa.accEn_o,
                     ifa.cmp_th_o, ifa.buffMembPot_o, ifa.wrEn_B_o,
                     ifa.rdEn_E_o, ifa.rdEn_A_o};
    assign strb_b = {ifb.busy_o, ifb.done_o, ifb.rstAcc_o, ifb.accEn_o,
                     ifb.cmp_th_o, ifb.buffMembPot_o, ifb.wrEn_B_o,
                     ifb.rdEn_E_o, ifb.rdEn_A_o};

    // Hand table for the 2-neuron / 4-axon step, j = cycles after start.
    function automatic logic [8:0] exp_2x4(input int j);
        logic [8:0] e;
        e    = '0;
        e[8] = (j >= 1 && j <= 22);
        e[7] = (j == 22);
        e[6] = (j == 2 || j == 12);
        e[5] = (j >= 3 && j <= 8) || (j >= 13 && j <= 18);
        e[4] = (j == 9 || j == 19);
        e[3] = (j == 9 || j == 19);
        e[2] = (j == 10 || j == 11 || j == 20 || j == 21);
        e[1] = (j >= 3 && j <= 6) || (j >= 13 && j <= 16);
        e[0] = (j == 2 || j == 7 || j == 8 ||
                j == 12 || j == 17 || j == 18);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.start_i = 1'b0;
        ifb.start_i = 1'b0;
        step();
        step();
        checks++;
        if (outs_a !== '0) begin
            errors++;
            $display("FAIL reset_a got %h exp 0", outs_a);
        end
        checks++;
        if (outs_b !== '0) begin
            errors++;
            $display("FAIL reset_b got %h exp 0", outs_b);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_timeline();
        int j;
        logic [1:0] es;
        ifa.start_i = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            ifa.start_i = (k == 5 || k == 22 || k == 23);
            j = (k >= 24) ? k - 23 : k;
            checks++;
            if (strb_a !== exp_2x4(j)) begin
                errors++;
                $display("FAIL strobes k=%0d got %b exp %b",
                         k, strb_a, exp_2x4(j));
            end
            if ((k >= 3 && k <= 6) || (k >= 13 && k <= 16)) begin
                checks++;
                if (ifa.axonAddr_o !== 8'((k - 3) % 10)) begin
                    errors++;
                    $display("FAIL axon_addr k=%0d got %0d exp %0d",
                             k, ifa.axonAddr_o, (k - 3) % 10);
                end
            end
            if ((k >= 3 && k <= 8) || (k >= 13 && k <= 18)) begin
                es = (k == 3 || k == 13) ? 2'b01 :
                     (k == 8 || k == 18) ? 2'b10 : 2'b00;
                checks++;
                if (ifa.sel_rclAdd_B_o !== es) begin
                    errors++;
                    $display("FAIL sel_rcl k=%0d got %b exp %b",
                             k, ifa.sel_rclAdd_B_o, es);
                end
            end
            if (k inside {2, 7, 8, 12, 17, 18}) begin
                es = (k == 2 || k == 12) ? 2'b00 :
                     (k == 7 || k == 17) ? 2'b01 : 2'b10;
                checks++;
                if (ifa.rdSel_A_o !== es) begin
                    errors++;
                    $display("FAIL rd_sel k=%0d got %b exp %b",
                             k, ifa.rdSel_A_o, es);
                end
            end
            if (k inside {10, 11, 20, 21, 23}) begin
                checks++;
                if (ifa.wrAddr_B_o !== ((k < 15) ? 8'd0 : 8'd1)) begin
                    errors++;
                    $display("FAIL wr_addr k=%0d got %0d", k,
                             ifa.wrAddr_B_o);
                end
            end
            if (k inside {10, 11, 20, 21}) begin
                es = (k == 10 || k == 20) ? 2'b01 : 2'b10;
                checks++;
                if (ifa.sel_wrBackStat_B_o !== es) begin
                    errors++;
                    $display("FAIL sel_wb k=%0d got %b exp %b",
                             k, ifa.sel_wrBackStat_B_o, es);
                end
            end
            if (k inside {1, 10, 11, 20, 23, 24}) begin
                checks++;
                if (ifa.nurnAddr_o !==
                    ((k >= 11 && k <= 23) ? 8'd1 : 8'd0)) begin
                    errors++;
                    $display("FAIL nurn_addr k=%0d got %0d", k,
                             ifa.nurnAddr_o);
                end
            end
        end
        ifa.start_i = 1'b0;
    endtask

    task automatic test_abort();
        logic [8:0] e;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        ifa.start_i = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            step();
            ifa.start_i = (k == 9);
            rst_a = (k == 7);
            if (k <= 7)
                e = exp_2x4(k);
            else if (k <= 9)
                e = '0;
            else
                e = exp_2x4(k - 9);
            checks++;
            if (strb_a !== e) begin
                errors++;
                $display("FAIL abort_strobes k=%0d got %b exp %b",
                         k, strb_a, e);
            end
            if (k == 8) begin
                checks++;
                if (outs_a !== '0) begin
                    errors++;
                    $display("FAIL abort_all_zero got %h exp 0", outs_a);
                end
            end
        end
        ifa.start_i = 1'b0;
    endtask

    task automatic test_small();
        logic [8:0] e;
        ifb.start_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            ifb.start_i = 1'b0;
            e    = '0;
            e[8] = (k >= 1 && k <= 9);
            e[7] = (k == 9);
            e[6] = (k == 2);
            e[5] = (k >= 3 && k <= 5);
            e[4] = (k == 6);
            e[3] = (k == 6);
            e[2] = (k == 7 || k == 8);
            e[1] = (k == 3);
            e[0] = (k == 2 || k == 4 || k == 5);
            checks++;
            if (strb_b !== e) begin
                errors++;
                $display("FAIL small_strobes k=%0d got %b exp %b",
                         k, strb_b, e);
            end
            checks++;
            if ({ifb.nurnAddr_o, ifb.axonAddr_o, ifb.wrAddr_B_o}
                !== 3'b000) begin
                errors++;
                $display("FAIL small_addr_range k=%0d got %b exp 000", k,
                         {ifb.nurnAddr_o, ifb.axonAddr_o,
                          ifb.wrAddr_B_o});
            end
            if (k == 5) begin
                checks++;
                if (ifb.rdSel_A_o !== 2'b10) begin
                    errors++;
                    $display("FAIL small_rd_sel got %b exp 10",
                             ifb.rdSel_A_o);
                end
            end
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.start_i = 1'b0;
        ifb.start_i = 1'b0;
        test_reset();
        test_timeline();
        test_abort();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
